// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational BW x AW multiplier
// between two requesters, returning each product over a per-requester response channel.
module mul_share_arbiter #(
  parameter int BW = 4,
  parameter int AW = 3,
  parameter int PW = BW + AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [BW-1:0] r0_b,
  input  logic [AW-1:0] r0_a,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [BW-1:0] r1_b,
  input  logic [AW-1:0] r1_a,
  output logic [BW-1:0] mul_b,
  output logic [AW-1:0] mul_a,
  input  logic [PW-1:0] mul_out,
  output logic [1:0]    resp_valid,
  output logic [PW-1:0] resp_data,
  input  logic [1:0]    resp_ready,
  output logic          busy,
  output logic          owner,
  output logic [1:0]    fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Requests: rX_ready is combinational and only ever high in IDLE for the selected
  // requester. Responses: resp_valid[owner] stays high with resp_data frozen until
  // resp_ready[owner] is seen; the non-owner's resp_ready bit has no effect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   rr_ptr;
  logic   sel;
  logic   accept;

  // With only one requester valid it wins outright; rr_ptr only breaks ties.
  always_comb begin
    sel = r1_valid;
    if (r0_valid && r1_valid) sel = rr_ptr;
  end

  assign r0_ready  = (state == IDLE) && !rst && r0_valid && !sel;
  assign r1_ready  = (state == IDLE) && !rst && r1_valid && sel;
  assign accept    = r0_ready || r1_ready;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      mul_b      <= '0;
      mul_a      <= '0;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_b <= sel ? r1_b : r0_b;
            mul_a <= sel ? r1_a : r0_a;
            owner <= sel;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // Operands have been stable on the multiplier for a full cycle.
          resp_data  <= mul_out;
          resp_valid <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= 2'b00;
            busy       <= 1'b0;
            rr_ptr     <= ~owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: reset, contention/round-robin, abort,
// backpressure and a full operand sweep on both requesters.
module tb_mul_share_arbiter;

  logic       clk;
  logic       rst;
  logic       r0_valid, r0_ready;
  logic [3:0] r0_b;
  logic [2:0] r0_a;
  logic       r1_valid, r1_ready;
  logic [3:0] r1_b;
  logic [2:0] r1_a;
  logic [3:0] mul_b;
  logic [2:0] mul_a;
  logic [6:0] mul_out;
  logic [1:0] resp_valid;
  logic [6:0] resp_data;
  logic [1:0] resp_ready;
  logic       busy;
  logic       owner;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  mul_share_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_b(r0_b), .r0_a(r0_a),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_b(r1_b), .r1_a(r1_a),
    .mul_b(mul_b), .mul_a(mul_a), .mul_out(mul_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .busy(busy), .owner(owner), .fsm_state(fsm_state)
  );

  // Stand-in for the shared multiplier instance.
  assign mul_out = {3'b000, mul_b} * {4'b0000, mul_a};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input int idx, input logic v, input logic [3:0] b, input logic [2:0] a);
    if (idx == 0) begin
      r0_valid = v; r0_b = b; r0_a = a;
    end else begin
      r1_valid = v; r1_b = b; r1_a = a;
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // One complete transaction by a lone requester, with optional response stall.
  task automatic serve(input int idx, input logic [3:0] b, input logic [2:0] a, input int stall);
    logic [6:0] e;
    logic [1:0] own_bit;
    e = {3'b000, b} * {4'b0000, a};
    own_bit = (idx == 0) ? 2'b01 : 2'b10;
    drive(idx, 1'b1, b, a);
    #1;
    chk("req_ready_own", (idx == 0) ? r0_ready : r1_ready, 1);
    chk("req_ready_other", (idx == 0) ? r1_ready : r0_ready, 0);
    next_cycle();
    drive(idx, 1'b0, 4'd0, 3'd0);
    #1;
    chk("calc_busy", busy, 1);
    chk("calc_owner", owner, idx);
    chk("calc_mul_b", mul_b, b);
    chk("calc_mul_a", mul_a, a);
    chk("calc_resp_valid", resp_valid, 0);
    next_cycle();
    for (int s = 0; s < stall; s++) begin
      chk("stall_resp_valid", resp_valid, own_bit);
      chk("stall_resp_data", resp_data, e);
      chk("stall_busy", busy, 1);
      chk("stall_ready", {r1_ready, r0_ready}, 0);
      resp_ready = ~own_bit;
      next_cycle();
    end
    chk("resp_valid", resp_valid, own_bit);
    chk("resp_data", resp_data, e);
    resp_ready = own_bit;
    next_cycle();
    resp_ready = 2'b00;
    chk("done_resp_valid", resp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_state", fsm_state, 0);
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r0_b = '0; r0_a = '0;
    r1_valid = 1'b0; r1_b = '0; r1_a = '0;
    resp_ready = 2'b00;

    // reset state
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_state", fsm_state, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_ready", {r1_ready, r0_ready}, 0);

    // contention from reset: r0 first, then r1, then r0 again
    drive(0, 1'b1, 4'd9, 3'd5);
    drive(1, 1'b1, 4'd14, 3'd6);
    #1;
    chk("cont_r0_ready", r0_ready, 1);
    chk("cont_r1_ready", r1_ready, 0);
    next_cycle();
    drive(0, 1'b0, 4'd0, 3'd0);
    #1;
    chk("cont_owner0", owner, 0);
    chk("cont_calc_ready", {r1_ready, r0_ready}, 0);
    chk("cont_mul_b0", mul_b, 9);
    next_cycle();
    chk("cont_rv0", resp_valid, 2'b01);
    chk("cont_data0", resp_data, 45);
    resp_ready = 2'b10;
    next_cycle();
    chk("cont_nonowner_ignored", resp_valid, 2'b01);
    chk("cont_nonowner_busy", busy, 1);
    drive(0, 1'b1, 4'd3, 3'd2);
    resp_ready = 2'b01;
    #1;
    chk("cont_resp_hs_no_accept", {r1_ready, r0_ready}, 0);
    next_cycle();
    resp_ready = 2'b00;
    #1;
    chk("cont_idle_busy", busy, 0);
    chk("cont_rr_r1_ready", r1_ready, 1);
    chk("cont_rr_r0_ready", r0_ready, 0);
    next_cycle();
    drive(1, 1'b0, 4'd0, 3'd0);
    #1;
    chk("cont_owner1", owner, 1);
    chk("cont_mul_b1", mul_b, 14);
    chk("cont_mul_a1", mul_a, 6);
    next_cycle();
    chk("cont_rv1", resp_valid, 2'b10);
    chk("cont_data1", resp_data, 84);
    resp_ready = 2'b10;
    next_cycle();
    resp_ready = 2'b00;
    chk("cont_r0_after", r0_ready, 1);
    next_cycle();
    drive(0, 1'b0, 4'd0, 3'd0);
    #1;
    chk("cont_owner0b", owner, 0);
    next_cycle();
    chk("cont_rv0b", resp_valid, 2'b01);
    chk("cont_data0b", resp_data, 6);
    resp_ready = 2'b01;
    next_cycle();
    resp_ready = 2'b00;
    chk("cont_done_busy", busy, 0);

    // abort during CALC (rr now points at r1; reset must move it back to r0)
    drive(1, 1'b1, 4'd5, 3'd3);
    #1;
    chk("abort_accept", r1_ready, 1);
    next_cycle();
    drive(1, 1'b0, 4'd0, 3'd0);
    chk("abort_in_calc", fsm_state, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", fsm_state, 0);
    chk("abort_resp_data", resp_data, 0);
    next_cycle();
    chk("abort_no_late_resp", resp_valid, 0);
    drive(0, 1'b1, 4'd1, 3'd1);
    drive(1, 1'b1, 4'd1, 3'd1);
    #1;
    chk("abort_rr_r0", r0_ready, 1);
    chk("abort_rr_r1", r1_ready, 0);
    drive(0, 1'b0, 4'd0, 3'd0);
    drive(1, 1'b0, 4'd0, 3'd0);
    next_cycle();

    // single max-operand product and backpressure
    serve(0, 4'b1111, 3'b111, 0);
    serve(1, 4'd11, 3'd1, 5);

    // full sweep on both requesters
    for (int idx = 0; idx < 2; idx++)
      for (int b = 0; b < 16; b++)
        for (int a = 0; a < 8; a++)
          serve(idx, 4'(b), 3'(a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
